// File: rtl/ise_sched_ctrl.sv
// ise_sched_ctrl: control and scheduling block for the image sorting engine.
// Paces pixel ingest, strobes the colour-classification datapath, collects one
// result per image into a table and then emits the batch in sorted order.
// Sort order: colour ascending, then key ascending, then index ascending.
//
// Ports:
//   clk, reset              clock (rising edge), async active-low reset
//   pix_vld, pix_idx        upstream pixel and the image it belongs to
//   busy                    registered back-pressure, 1 = pixel not accepted
//   acc_clr/acc_en/img_done datapath strobes, combinational from pixel accept
//   cls_vld/cls_color/cls_key  classification result for the current image
//   out_valid/color_index/image_out_index  sorted result stream (registered)
//   idx_err                 only with ISE_IDX_CHK_EN: sticky index-consistency flag
//
// Optional feature macro: ISE_IDX_CHK_EN
module ise_sched_ctrl #(
    parameter int unsigned IMG_NUM     = 32,
    parameter int unsigned PIX_PER_IMG = 16384,
    parameter int unsigned KEY_W       = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             pix_vld,
    input  logic [4:0]       pix_idx,
    output logic             busy,
    output logic             acc_clr,
    output logic             acc_en,
    output logic             img_done,
    input  logic             cls_vld,
    input  logic [1:0]       cls_color,
    input  logic [KEY_W-1:0] cls_key,
    output logic             out_valid,
    output logic [1:0]       color_index,
    output logic [4:0]       image_out_index
`ifdef ISE_IDX_CHK_EN
    ,
    output logic             idx_err
`endif
);

    localparam int unsigned IDX_W = 5;
    localparam int unsigned TAW   = (IMG_NUM > 1) ? $clog2(IMG_NUM) : 1;
    localparam int unsigned ICW   = $clog2(IMG_NUM + 1);
    localparam int unsigned PCW   = (PIX_PER_IMG > 1) ? $clog2(PIX_PER_IMG) : 1;

    typedef enum logic [2:0] {
        S_LOAD,
        S_WAIT_CLS,
        S_SCAN,
        S_EMIT,
        S_DONE
    } state_t;

    // Packed so that a plain compare orders by colour first, then key.
    typedef struct packed {
        logic [1:0]       color;
        logic [KEY_W-1:0] key;
    } entry_t;

    state_t             state, state_next;
    logic [PCW-1:0]     pix_cnt;
    logic [ICW-1:0]     img_cnt, emit_cnt;
    logic [IDX_W-1:0]   cur_idx, scan_ptr, best_idx, win_idx;
    logic [IMG_NUM-1:0] tbl_vld, tbl_emit;
    entry_t             tbl [IMG_NUM];
    entry_t             best, win;
    logic               best_found, win_found;
    logic               accept, last_pix, cls_wr, batch_full;
    logic               scan_last, emit_last, cand_better;
    logic [TAW-1:0]     cur_slot, scan_slot, out_slot;

    assign cur_slot  = cur_idx[TAW-1:0];
    assign scan_slot = scan_ptr[TAW-1:0];
    assign out_slot  = image_out_index[TAW-1:0];

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= S_LOAD;
        else        state <= state_next;
    end

    // Next state, datapath strobes and running-minimum selection
    always_comb begin
        state_next  = state;
        accept      = 1'b0;
        acc_en      = 1'b0;
        acc_clr     = 1'b0;
        img_done    = 1'b0;
        cls_wr      = 1'b0;
        last_pix    = (pix_cnt == PCW'(PIX_PER_IMG - 1));
        batch_full  = ((img_cnt + ICW'(1)) == ICW'(IMG_NUM));
        scan_last   = (scan_ptr == IDX_W'(IMG_NUM - 1));
        emit_last   = ((emit_cnt + ICW'(1)) == ICW'(IMG_NUM));
        // Strict less-than keeps the earlier (lower) index on ties.
        cand_better = tbl_vld[scan_slot] && !tbl_emit[scan_slot] &&
                      (!best_found || (tbl[scan_slot] < best));
        win         = cand_better ? tbl[scan_slot] : best;
        win_idx     = cand_better ? scan_ptr : best_idx;
        win_found   = best_found || cand_better;

        case (state)
            S_LOAD: begin
                accept   = pix_vld && !busy;
                acc_en   = accept;
                acc_clr  = accept && (pix_cnt == '0);
                img_done = accept && last_pix;
                if (img_done) state_next = S_WAIT_CLS;
            end
            S_WAIT_CLS: begin
                cls_wr = cls_vld;
                if (cls_vld) state_next = batch_full ? S_SCAN : S_LOAD;
            end
            // A scan with nothing left (repeated indices left holes) ends the batch.
            S_SCAN:  if (scan_last) state_next = win_found ? S_EMIT : S_DONE;
            S_EMIT:  state_next = emit_last ? S_DONE : S_SCAN;
            S_DONE:  state_next = S_LOAD;
            default: state_next = S_LOAD;
        endcase
    end

    // Counters, table status bits, scan registers and result outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            busy            <= 1'b0;
            pix_cnt         <= '0;
            cur_idx         <= '0;
            img_cnt         <= '0;
            emit_cnt        <= '0;
            tbl_vld         <= '0;
            tbl_emit        <= '0;
            scan_ptr        <= '0;
            best            <= '0;
            best_idx        <= '0;
            best_found      <= 1'b0;
            out_valid       <= 1'b0;
            color_index     <= '0;
            image_out_index <= '0;
        end else begin
            out_valid <= 1'b0;
            if (accept) begin
                pix_cnt <= last_pix ? '0 : pix_cnt + PCW'(1);
                if (pix_cnt == '0) cur_idx <= pix_idx;
                if (last_pix) busy <= 1'b1;
            end
            if (cls_wr) begin
                tbl_vld[cur_slot] <= 1'b1;
                img_cnt           <= img_cnt + ICW'(1);
                if (!batch_full) busy <= 1'b0;
            end
            if (state == S_SCAN) begin
                if (scan_last) begin
                    scan_ptr   <= '0;
                    best_found <= 1'b0;
                    if (win_found) begin
                        out_valid       <= 1'b1;
                        color_index     <= win.color;
                        image_out_index <= win_idx;
                    end
                end else begin
                    scan_ptr   <= scan_ptr + IDX_W'(1);
                    best       <= win;
                    best_idx   <= win_idx;
                    best_found <= win_found;
                end
            end
            if (state == S_EMIT) begin
                tbl_emit[out_slot] <= 1'b1;
                emit_cnt           <= emit_cnt + ICW'(1);
            end
            if (state == S_DONE) begin
                busy     <= 1'b0;
                pix_cnt  <= '0;
                img_cnt  <= '0;
                emit_cnt <= '0;
                tbl_vld  <= '0;
                tbl_emit <= '0;
            end
        end
    end

    // Result table payload; validity is tracked separately in tbl_vld
    always_ff @(posedge clk) begin
        if (cls_wr) tbl[cur_slot] <= {cls_color, cls_key};
    end

`ifdef ISE_IDX_CHK_EN
    // Sticky flag: pixel index drifted mid-image, or an entry was written twice
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_err <= 1'b0;
        end else if ((accept && (pix_cnt != '0) && (pix_idx != cur_idx)) ||
                     (cls_wr && tbl_vld[cur_slot])) begin
            idx_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_ise_sched_ctrl.sv
// Self-checking bench for ise_sched_ctrl with a 4-image, 4-pixel batch.
// Expected emission order is produced by sorting the loaded results in the
// bench and queued; observed out_valid strobes are popped against it.
module tb_ise_sched_ctrl;

    localparam int unsigned IMG_NUM = 4;
    localparam int unsigned PIX     = 4;
    localparam int unsigned KEY_W   = 16;

    logic             clk;
    logic             reset;
    logic             pix_vld;
    logic [4:0]       pix_idx;
    logic             busy, acc_clr, acc_en, img_done;
    logic             cls_vld;
    logic [1:0]       cls_color;
    logic [KEY_W-1:0] cls_key;
    logic             out_valid;
    logic [1:0]       color_index;
    logic [4:0]       image_out_index;
`ifdef ISE_IDX_CHK_EN
    logic             idx_err;
`endif

    int errors = 0;
    int checks = 0;

    logic [1:0]  b_col [4];
    logic [15:0] b_key [4];
    int exp_q[$];
    int obs_col[$];
    int obs_idx[$];
    int obs_cyc[$];

    ise_sched_ctrl #(
        .IMG_NUM(IMG_NUM),
        .PIX_PER_IMG(PIX),
        .KEY_W(KEY_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .pix_vld(pix_vld),
        .pix_idx(pix_idx),
        .busy(busy),
        .acc_clr(acc_clr),
        .acc_en(acc_en),
        .img_done(img_done),
        .cls_vld(cls_vld),
        .cls_color(cls_color),
        .cls_key(cls_key),
        .out_valid(out_valid),
        .color_index(color_index),
        .image_out_index(image_out_index)
`ifdef ISE_IDX_CHK_EN
        ,
        .idx_err(idx_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    // Push expected (color*32+index) values in sorted order
    task automatic push_expected();
        int v[$];
        for (int i = 0; i < 4; i++)
            v.push_back((int'(b_col[i]) << 21) | (int'(b_key[i]) << 5) | i);
        v.sort();
        foreach (v[k]) exp_q.push_back(((v[k] >> 21) & 3) * 32 + (v[k] & 31));
    endtask

    // Feed one image, wait 3 cycles, deliver its classification; report observations
    task automatic load_image(input logic [4:0] idx0, input logic [4:0] idxn,
                              input logic [1:0] col, input logic [15:0] key,
                              input bit toggle,
                              output int n_en, output int n_clr, output int clr_pos,
                              output int done_pos, output int cycles,
                              output int busy_bad, output logic busy_after);
        int acc;
        bit ph;
        n_en = 0; n_clr = 0; clr_pos = -1; done_pos = -1; cycles = 0;
        busy_bad = 0; acc = 0; ph = 1'b1;
        for (int c = 0; c < 40 && done_pos < 0; c++) begin
            @(negedge clk);
            pix_vld = toggle ? ph : 1'b1;
            ph = ~ph;
            pix_idx = (acc == 0) ? idx0 : idxn;
            #1;
            cycles++;
            if (acc_en) begin
                n_en++;
                if (acc_clr) begin n_clr++; clr_pos = acc; end
                if (img_done) done_pos = acc;
                acc++;
            end
        end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); #1;
            if (!busy || acc_en) busy_bad++;
        end
        @(negedge clk);
        cls_vld = 1'b1; cls_color = col; cls_key = key;
        #1;
        if (!busy || acc_en) busy_bad++;
        @(negedge clk);
        cls_vld = 1'b0; pix_vld = 1'b0;
        #1;
        busy_after = busy;
    endtask

    // Record out_valid strobes (no comparison) until n seen or budget spent
    task automatic collect_out(input int n, input int budget);
        obs_col.delete(); obs_idx.delete(); obs_cyc.delete();
        for (int c = 0; c < budget && obs_col.size() < n; c++) begin
            @(negedge clk);
            if (out_valid) begin
                obs_col.push_back(int'(color_index));
                obs_idx.push_back(int'(image_out_index));
                obs_cyc.push_back(c);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; pix_vld = 1'b0; pix_idx = '0;
        cls_vld = 1'b0; cls_color = '0; cls_key = '0;
        #2 reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", busy); end
        checks++; if (acc_en !== 1'b0) begin errors++; $display("FAIL reset_acc_en: got %0b expected 0", acc_en); end
        checks++; if (acc_clr !== 1'b0) begin errors++; $display("FAIL reset_acc_clr: got %0b expected 0", acc_clr); end
        checks++; if (img_done !== 1'b0) begin errors++; $display("FAIL reset_img_done: got %0b expected 0", img_done); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %0b expected 0", out_valid); end
        checks++; if (color_index !== 2'd0) begin errors++; $display("FAIL reset_color: got %0d expected 0", color_index); end
        checks++; if (image_out_index !== 5'd0) begin errors++; $display("FAIL reset_index: got %0d expected 0", image_out_index); end
`ifdef ISE_IDX_CHK_EN
        checks++; if (idx_err !== 1'b0) begin errors++; $display("FAIL reset_idx_err: got %0b expected 0", idx_err); end
`endif
        reset = 1'b1;
    endtask

    task automatic test_sort();
        int n_en, n_clr, clr_pos, done_pos, cyc, bb, e;
        logic ba;
        b_col = '{2'd2, 2'd0, 2'd0, 2'd1};
        b_key = '{16'd5, 16'd9, 16'd3, 16'd0};
        push_expected();
        for (int i = 0; i < 4; i++) begin
            load_image(5'(i), 5'(i), b_col[i], b_key[i], 1'b0, n_en, n_clr, clr_pos, done_pos, cyc, bb, ba);
            checks++; if (n_en !== 4) begin errors++; $display("FAIL sort_acc_en img%0d: got %0d expected 4", i, n_en); end
            checks++; if (done_pos !== 3) begin errors++; $display("FAIL sort_img_done img%0d: got pixel %0d expected 3", i, done_pos); end
            checks++; if (ba !== ((i == 3) ? 1'b1 : 1'b0)) begin errors++; $display("FAIL sort_busy_after_cls img%0d: got %0b expected %0b", i, ba, (i == 3)); end
            if (i == 0) begin
                checks++; if (n_clr !== 1 || clr_pos !== 0) begin errors++; $display("FAIL sort_acc_clr: got count %0d at %0d expected 1 at 0", n_clr, clr_pos); end
                checks++; if (bb !== 0) begin errors++; $display("FAIL sort_busy_hold: got %0d bad cycles expected 0", bb); end
            end
        end
        collect_out(4, 80);
        checks++; if (obs_col.size() !== 4) begin errors++; $display("FAIL sort_out_count: got %0d expected 4", obs_col.size()); end
        for (int k = 0; k < obs_col.size(); k++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            checks++; if (obs_col[k] * 32 + obs_idx[k] !== e) begin errors++; $display("FAIL sort_out%0d: got (%0d,%0d) expected (%0d,%0d)", k, obs_col[k], obs_idx[k], e / 32, e % 32); end
            if (k > 0) begin
                checks++; if (obs_cyc[k] - obs_cyc[k-1] !== 5) begin errors++; $display("FAIL sort_spacing%0d: got %0d expected 5", k, obs_cyc[k] - obs_cyc[k-1]); end
            end
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL sort_busy_release: got %0b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sort_no_extra_out: got %0b expected 0", out_valid); end
    endtask

    task automatic test_ties_toggle();
        int n_en, n_clr, clr_pos, done_pos, cyc, bb, e;
        logic ba;
        b_col = '{2'd1, 2'd1, 2'd1, 2'd1};
        b_key = '{16'd7, 16'd7, 16'd7, 16'd7};
        push_expected();
        for (int i = 0; i < 4; i++) begin
            load_image(5'(i), 5'(i), b_col[i], b_key[i], (i == 0), n_en, n_clr, clr_pos, done_pos, cyc, bb, ba);
            if (i == 0) begin
                checks++; if (n_en !== 4) begin errors++; $display("FAIL toggle_acc_en: got %0d expected 4", n_en); end
                checks++; if (cyc !== 7) begin errors++; $display("FAIL toggle_done_cycle: got %0d expected 7", cyc); end
                checks++; if (done_pos !== 3) begin errors++; $display("FAIL toggle_img_done: got pixel %0d expected 3", done_pos); end
            end
        end
        collect_out(4, 80);
        checks++; if (obs_col.size() !== 4) begin errors++; $display("FAIL ties_out_count: got %0d expected 4", obs_col.size()); end
        for (int k = 0; k < obs_col.size(); k++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            checks++; if (obs_col[k] * 32 + obs_idx[k] !== e) begin errors++; $display("FAIL ties_out%0d: got (%0d,%0d) expected (%0d,%0d)", k, obs_col[k], obs_idx[k], e / 32, e % 32); end
        end
        exp_q.delete();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset_mid_scan();
        int n_en, n_clr, clr_pos, done_pos, cyc, bb, e;
        int ord[4];
        logic ba;
        b_col = '{2'd3, 2'd1, 2'd1, 2'd0};
        b_key = '{16'd1, 16'd2, 16'd1, 16'd9};
        for (int i = 0; i < 4; i++)
            load_image(5'(i), 5'(i), b_col[i], b_key[i], 1'b0, n_en, n_clr, clr_pos, done_pos, cyc, bb, ba);
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy: got %0b expected 0", busy); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %0b expected 0", out_valid); end
        checks++; if (color_index !== 2'd0) begin errors++; $display("FAIL midrst_color: got %0d expected 0", color_index); end
        checks++; if (image_out_index !== 5'd0) begin errors++; $display("FAIL midrst_index: got %0d expected 0", image_out_index); end
        @(negedge clk);
        reset = 1'b1;
        b_col = '{2'd0, 2'd3, 2'd2, 2'd0};
        b_key = '{16'd4, 16'd1, 16'd1, 16'd2};
        ord = '{3, 1, 0, 2};
        push_expected();
        for (int j = 0; j < 4; j++) begin
            load_image(5'(ord[j]), 5'(ord[j]), b_col[ord[j]], b_key[ord[j]], 1'b0, n_en, n_clr, clr_pos, done_pos, cyc, bb, ba);
            if (j == 0) begin
                checks++; if (n_clr !== 1 || clr_pos !== 0) begin errors++; $display("FAIL midrst_first_clr: got count %0d at %0d expected 1 at 0", n_clr, clr_pos); end
                checks++; if (done_pos !== 3) begin errors++; $display("FAIL midrst_first_done: got pixel %0d expected 3", done_pos); end
            end
        end
        collect_out(4, 80);
        checks++; if (obs_col.size() !== 4) begin errors++; $display("FAIL midrst_out_count: got %0d expected 4", obs_col.size()); end
        for (int k = 0; k < obs_col.size(); k++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : -1;
            checks++; if (obs_col[k] * 32 + obs_idx[k] !== e) begin errors++; $display("FAIL midrst_out%0d: got (%0d,%0d) expected (%0d,%0d)", k, obs_col[k], obs_idx[k], e / 32, e % 32); end
        end
        exp_q.delete();
        collect_out(1, 12);
        checks++; if (obs_col.size() !== 0) begin errors++; $display("FAIL midrst_stale_out: got %0d extra strobes expected 0", obs_col.size()); end
    endtask

`ifdef ISE_IDX_CHK_EN
    task automatic test_idx_err();
        int n_en, n_clr, clr_pos, done_pos, cyc, bb;
        logic ba;
        checks++; if (idx_err !== 1'b0) begin errors++; $display("FAIL idxerr_initial: got %0b expected 0", idx_err); end
        load_image(5'd3, 5'd5, 2'd0, 16'd1, 1'b0, n_en, n_clr, clr_pos, done_pos, cyc, bb, ba);
        checks++; if (idx_err !== 1'b1) begin errors++; $display("FAIL idxerr_set: got %0b expected 1", idx_err); end
        for (int i = 0; i < 3; i++)
            load_image(5'(i), 5'(i), 2'd1, 16'd2, 1'b0, n_en, n_clr, clr_pos, done_pos, cyc, bb, ba);
        collect_out(4, 80);
        checks++; if (obs_col.size() !== 4) begin errors++; $display("FAIL idxerr_out_count: got %0d expected 4", obs_col.size()); end
        repeat (2) @(negedge clk);
        checks++; if (idx_err !== 1'b1) begin errors++; $display("FAIL idxerr_sticky: got %0b expected 1", idx_err); end
        #2 reset = 1'b0;
        #1;
        checks++; if (idx_err !== 1'b0) begin errors++; $display("FAIL idxerr_reset: got %0b expected 0", idx_err); end
        @(negedge clk);
        reset = 1'b1;
    endtask
`endif

    initial begin
        test_reset();
        test_sort();
        test_ties_toggle();
        test_reset_mid_scan();
`ifdef ISE_IDX_CHK_EN
        test_idx_err();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
